fifo_read_arbiter: RTL and testbench

- Round-robin scheduler sharing the single read port of the dual-clock async FIFO among NREQ read-domain consumers.
- Sits in the read clock domain, directly beside the read-pointer handler. Consumes its empty flag and the FIFO memory's read data.
- Drives rinc, and delivers words to the granted consumer through a one-entry registered output stage with valid/ready handshake.
- Grants are burst-limited so no consumer can monopolise the FIFO.

---
 rtl/fifo_read_arbiter.sv | 111 +++++++++++
 tb/tb_fifo_read_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_arbiter.sv
// Round-robin, burst-limited sharing of the async FIFO read port; popped word shows on dout one cycle later.
// Backpressure: a held word blocks further pops until ready[g]; an empty FIFO ends the grant early.
module fifo_read_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            rresetn,
  input  logic            empty,
  input  logic [DW-1:0]   rdata,
  output logic            rinc,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] ready,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] dvalid,
  output logic [DW-1:0]   dout,
  output logic            busy
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BURST + 1);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;

  state_t          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [IW-1:0]   g_q;
  logic [IW-1:0]   last_q;
  logic [CW-1:0]   cnt_q;
  logic            ovalid_q;
  logic [DW-1:0]   dout_q;

  logic          req_g;
  logic          rdy_g;
  logic          pop;
  logic          consume;
  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] scan_idx;

  assign req_g   = req[g_q];
  assign rdy_g   = ready[g_q];
  assign pop     = (state_q == S_BURST) & ~empty & req_g & (cnt_q < CW'(BURST)) & (~ovalid_q | rdy_g);
  assign consume = ovalid_q & rdy_g;

  assign rinc   = pop;
  assign gnt    = gnt_q;
  assign dvalid = gnt_q & {NREQ{ovalid_q}};
  assign dout   = dout_q;
  assign busy   = (state_q != S_IDLE);

  // Scan upward from last+1 with wrap; the first set request wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = last_q;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = (scan_idx == IW'(NREQ - 1)) ? '0 : scan_idx + 1'b1;
      if (!pick_vld && req[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rresetn) begin
    if (!rresetn) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      g_q      <= '0;
      last_q   <= IW'(NREQ - 1);
      cnt_q    <= '0;
      ovalid_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld && !empty) begin
            gnt_q   <= ONE << pick_idx;
            g_q     <= pick_idx;
            cnt_q   <= '0;
            state_q <= S_BURST;
          end
        end
        S_BURST: begin
          if (pop) begin
            dout_q   <= rdata;
            ovalid_q <= 1'b1;
            cnt_q    <= cnt_q + 1'b1;
          end else if (consume) begin
            ovalid_q <= 1'b0;
          end
          // Leave on a full burst, a dropped request, or an empty FIFO with nothing held.
          if ((pop && cnt_q == CW'(BURST - 1)) || !req_g || (empty && !ovalid_q)) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!ovalid_q || rdy_g) begin
            gnt_q    <= '0;
            ovalid_q <= 1'b0;
            last_q   <= g_q;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed and randomized checks of fifo_read_arbiter against a transaction-level model
// (FIFO as a queue, round-robin rule, word ordering and handshake invariants).
module tb_fifo_read_arbiter;
  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int BURST = 4;
  localparam int IW    = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  logic            clk = 1'b0;
  logic            rresetn;
  logic            empty;
  logic [DW-1:0]   rdata;
  logic            rinc;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] ready;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] dvalid;
  logic [DW-1:0]   dout;
  logic            busy;

  fifo_read_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
    .clk(clk), .rresetn(rresetn), .empty(empty), .rdata(rdata), .rinc(rinc),
    .req(req), .ready(ready), .gnt(gnt), .dvalid(dvalid), .dout(dout), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] inflight[$];
  int grant_log[$];
  int pops_log[$];
  int last_m, cur_g, pops_in_grant, delivered;

  logic            prev_rinc, prev_busy, prev_empty;
  logic [NREQ-1:0] prev_gnt, prev_dvalid, prev_ready, prev_req;
  logic [DW-1:0]   prev_word, prev_dout;

  logic            s_rinc, s_busy;
  logic [NREQ-1:0] s_gnt, s_dvalid;
  logic [DW-1:0]   s_dout;

  int t2_rinc [13] = '{0, 1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
  int t2_gnt  [13] = '{0, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0};
  int t2_dv   [13] = '{0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0};
  int t2_dout [13] = '{0, 0, 'hA0, 'hA1, 'hA2, 'hA3, 0, 0, 'hA4, 'hA5, 0, 0, 0};
  int t5_rinc [7]  = '{0, 1, 1, 0, 0, 0, 0};
  int t5_gnt  [7]  = '{0, 2, 2, 2, 2, 2, 0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
    for (int off = 1; off <= NREQ; off++)
      if (r[IW'((last + off) % NREQ)]) return (last + off) % NREQ;
    return 0;
  endfunction

  task automatic clear_model();
    inflight.delete();
    last_m = NREQ - 1;
    cur_g = -1;
    pops_in_grant = 0;
    prev_rinc = 1'b0; prev_busy = 1'b0; prev_empty = 1'b1;
    prev_gnt = '0; prev_dvalid = '0; prev_ready = '0; prev_req = '0;
    prev_word = '0; prev_dout = '0;
  endtask

  task automatic drive_fifo();
    empty = (fifo_q.size() == 0);
    rdata = empty ? DW'('hEE) : fifo_q[0];
  endtask

  task automatic monitor();
    logic [NREQ-1:0] exp_g;
    s_rinc = rinc; s_busy = busy; s_gnt = gnt; s_dvalid = dvalid; s_dout = dout;
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'(1));
    chk("rinc_while_empty", 32'(rinc & empty), 32'(0));
    chk("rinc_without_grant", 32'(rinc & ((gnt & req) == '0)), 32'(0));
    chk("dvalid_outside_gnt", 32'(dvalid & ~gnt), 32'(0));
    if (!prev_busy) begin
      exp_g = '0;
      if (prev_req != '0 && !prev_empty) exp_g = ONE << rr_pick(last_m, prev_req);
      chk("arbitration", 32'(gnt), 32'(exp_g));
    end
    if (prev_gnt != '0 && gnt != '0) chk("grant_held", 32'(gnt), 32'(prev_gnt));
    if (prev_gnt == '0 && gnt != '0) begin
      cur_g = $clog2(gnt);
      pops_in_grant = 0;
    end
    if (prev_gnt != '0 && gnt == '0) begin
      grant_log.push_back(cur_g);
      pops_log.push_back(pops_in_grant);
      last_m = cur_g;
    end
    if (prev_rinc) begin
      chk("pop_to_dvalid", 32'(dvalid), 32'(prev_gnt));
      chk("pop_to_dout", 32'(dout), 32'(prev_word));
    end
    if ((prev_dvalid & ~prev_ready) != '0) begin
      chk("stall_dvalid", 32'(dvalid), 32'(prev_dvalid));
      chk("stall_dout", 32'(dout), 32'(prev_dout));
    end
    if ((dvalid & ready) != '0) begin
      if (inflight.size() == 0) chk("spurious_word", 32'(dvalid & ready), 32'(0));
      else begin
        chk("word_order", 32'(dout), 32'(inflight.pop_front()));
        delivered++;
      end
    end
    if (rinc && fifo_q.size() > 0) begin
      pops_in_grant++;
      chk("burst_cap", 32'(pops_in_grant > BURST), 32'(0));
      prev_word = fifo_q[0];
      inflight.push_back(fifo_q[0]);
    end
    prev_rinc = rinc; prev_busy = busy; prev_empty = empty;
    prev_gnt = gnt; prev_dvalid = dvalid; prev_ready = ready; prev_req = req; prev_dout = dout;
  endtask

  task automatic step();
    drive_fifo();
    @(negedge clk);
    monitor();
    @(posedge clk);
    if (s_rinc && rresetn && fifo_q.size() > 0) void'(fifo_q.pop_front());
    #1;
  endtask

  task automatic do_reset();
    drive_fifo();
    rresetn = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_dvalid", 32'(dvalid), 32'(0));
    chk("rst_rinc", 32'(rinc), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_dout", 32'(dout), 32'(0));
    clear_model();
    step();
    clear_model();
    rresetn = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 60; k++) begin
      step();
      if (!s_busy) break;
    end
    chk(tag, 32'(s_busy), 32'(0));
    chk({tag, "_inflight"}, 32'(inflight.size()), 32'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w[6];
    req = '1; ready = '1; rresetn = 1'b0; delivered = 0;
    clear_model();

    // Reset with requests pending and data available.
    for (int i = 0; i < 3; i++) fifo_q.push_back(DW'($urandom));
    do_reset();
    req = '0;
    fifo_q.delete();
    step(); step();

    // Single consumer, two bursts, early end on empty.
    for (int i = 0; i < 6; i++) fifo_q.push_back(DW'('hA0 + i));
    req = 4'b0001; ready = 4'b0001;
    for (int k = 0; k < 13; k++) begin
      step();
      chk($sformatf("t2_rinc_%0d", k), 32'(s_rinc), t2_rinc[k]);
      chk($sformatf("t2_gnt_%0d", k), 32'(s_gnt), t2_gnt[k]);
      chk($sformatf("t2_dvalid_%0d", k), 32'(s_dvalid), t2_dv[k]);
      if (t2_dv[k] != 0) chk($sformatf("t2_dout_%0d", k), 32'(s_dout), t2_dout[k]);
    end
    chk("t2_busy_end", 32'(s_busy), 32'(0));

    // Round robin from a fresh pointer with the FIFO kept full.
    req = '0;
    do_reset();
    grant_log.delete(); pops_log.delete(); delivered = 0;
    for (int i = 0; i < 40; i++) fifo_q.push_back(DW'($urandom));
    req = '1; ready = '1;
    for (int k = 0; k < 200 && grant_log.size() < 5; k++) step();
    req = '0;
    wait_idle("t3_idle");
    chk("t3_grants", 32'(grant_log.size() >= 5), 32'(1));
    for (int k = 0; k < 5 && k < grant_log.size(); k++) begin
      chk($sformatf("t3_grant_%0d", k), 32'(grant_log[k]), 32'(k % NREQ));
      chk($sformatf("t3_pops_%0d", k), 32'(pops_log[k]), 32'(BURST));
    end
    chk("t3_delivered", 32'(delivered), 32'(40 - fifo_q.size()));
    fifo_q.delete();

    // Backpressure on consumer 0 after its first word.
    for (int i = 0; i < 6; i++) begin
      w[i] = DW'($urandom);
      fifo_q.push_back(w[i]);
    end
    req = 4'b0001; ready = 4'b0001;
    step(); chk("t4_idle_gnt", 32'(s_gnt), 32'(0));
    step(); chk("t4_pop0", 32'(s_rinc), 32'(1));
    step(); chk("t4_word0", 32'(s_dout), 32'(w[0]));
    ready = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t4_stall_rinc_%0d", k), 32'(s_rinc), 32'(0));
      chk($sformatf("t4_stall_dvalid_%0d", k), 32'(s_dvalid), 32'(1));
      chk($sformatf("t4_stall_dout_%0d", k), 32'(s_dout), 32'(w[1]));
    end
    ready = 4'b0001;
    step(); chk("t4_resume_rinc", 32'(s_rinc), 32'(1));
    step(); chk("t4_word2", 32'(s_dout), 32'(w[2]));
    step(); chk("t4_word3", 32'(s_dout), 32'(w[3]));
    req = '0;
    wait_idle("t4_idle");
    fifo_q.delete();

    // Empty mid-burst on consumer 1.
    for (int i = 0; i < 2; i++) begin
      w[i] = DW'($urandom);
      fifo_q.push_back(w[i]);
    end
    req = 4'b0010; ready = '1;
    for (int k = 0; k < 7; k++) begin
      step();
      chk($sformatf("t5_rinc_%0d", k), 32'(s_rinc), t5_rinc[k]);
      chk($sformatf("t5_gnt_%0d", k), 32'(s_gnt), t5_gnt[k]);
      if (k == 2 || k == 3) chk($sformatf("t5_dout_%0d", k), 32'(s_dout), 32'(w[k - 2]));
    end
    chk("t5_busy_end", 32'(s_busy), 32'(0));

    // Reset after the second pop of a burst.
    for (int i = 0; i < 8; i++) fifo_q.push_back(DW'($urandom));
    req = 4'b1001;
    step(); step(); step();
    chk("t6_gnt_before", 32'(s_gnt), 32'(4'b1000));
    chk("t6_left", 32'(fifo_q.size()), 32'(6));
    do_reset();
    step(); chk("t6_idle_after", 32'(s_gnt), 32'(0));
    step(); chk("t6_first_grant", 32'(s_gnt), 32'(4'b0001));
    req = '0;
    wait_idle("t6_idle");
    fifo_q.delete();

    // Randomized traffic; the monitor checks every cycle.
    for (int k = 0; k < 400; k++) begin
      if (($urandom_range(0, 2) == 0) && fifo_q.size() < 12) fifo_q.push_back(DW'($urandom));
      if (k % 8 == 0) req = NREQ'($urandom);
      ready = NREQ'($urandom | $urandom);
      step();
    end
    req = '0; ready = '1;
    wait_idle("t7_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
